debounce_botoes: RTL and testbench

DEBOUNCE_BOTOES -- requirements
Module: debounce_botoes

---
 rtl/elevador_pkg.sv | 13 +
 rtl/debounce_botoes_if.sv | 23 ++
 rtl/debounce_canal.sv | 107 ++++++++++
 rtl/debounce_botoes.sv | 51 +++++
 tb/tb_debounce_botoes.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/elevador_pkg.sv
// rtl/elevador_pkg.sv - shared types for the elevator call-button front end
package elevador_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    SOLTO          = 2'b00,
    CONFIRMA_PRESS = 2'b01,
    PRESSIONADO    = 2'b10,
    CONFIRMA_SOLTA = 2'b11
  } estado_t;

endpackage

// File: rtl/debounce_botoes_if.sv
// rtl/debounce_botoes_if.sv - button/call bus between the panel and the elevator controller
interface debounce_botoes_if #(
  parameter int N_BOTOES = 4
);

  logic [N_BOTOES-1:0] botoes_n;
  logic [N_BOTOES-1:0] atendido;
  logic [N_BOTOES-1:0] pulso;
  logic [N_BOTOES-1:0] estavel;
  logic [N_BOTOES-1:0] chamadas;
  logic                alguma_chamada;

  modport master (
    output botoes_n, atendido,
    input  pulso, estavel, chamadas, alguma_chamada
  );

  modport slave (
    input  botoes_n, atendido,
    output pulso, estavel, chamadas, alguma_chamada
  );

endinterface

// File: rtl/debounce_canal.sv
// rtl/debounce_canal.sv - one button channel: synchronizer, debounce FSM, press pulse
module debounce_canal
  import elevador_pkg::*;
#(
  parameter int N_AMOSTRAS = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic botao_n,
  output logic pulso,
  output logic estavel
);

  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(N_AMOSTRAS - 1);
  localparam logic [CNT_W-1:0] UM     = CNT_W'(1);

  logic             sinc1_q, sinc2_q;
  logic             s;
  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulso_q, pulso_d;
  logic             estavel_q, estavel_d;

  assign s = ~sinc2_q;

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    pulso_d  = 1'b0;
    case (estado_q)
      SOLTO: begin
        if (s) begin
          if (N_AMOSTRAS == 1) begin
            estado_d = PRESSIONADO;
            cnt_d    = '0;
            pulso_d  = 1'b1;
          end else begin
            estado_d = CONFIRMA_PRESS;
            cnt_d    = UM;
          end
        end
      end
      CONFIRMA_PRESS: begin
        if (!s) begin
          estado_d = SOLTO;
          cnt_d    = '0;
        end else if (cnt_q == ULTIMO) begin
          estado_d = PRESSIONADO;
          cnt_d    = '0;
          pulso_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + UM;
        end
      end
      PRESSIONADO: begin
        if (!s) begin
          if (N_AMOSTRAS == 1) begin
            estado_d = SOLTO;
            cnt_d    = '0;
          end else begin
            estado_d = CONFIRMA_SOLTA;
            cnt_d    = UM;
          end
        end
      end
      CONFIRMA_SOLTA: begin
        // a bounce back to pressed is not a new press, so no pulse here
        if (s) begin
          estado_d = PRESSIONADO;
          cnt_d    = '0;
        end else if (cnt_q == ULTIMO) begin
          estado_d = SOLTO;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + UM;
        end
      end
      default: begin
        estado_d = SOLTO;
        cnt_d    = '0;
      end
    endcase
    estavel_d = (estado_d == PRESSIONADO) || (estado_d == CONFIRMA_SOLTA);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sinc1_q   <= 1'b1;
      sinc2_q   <= 1'b1;
      estado_q  <= SOLTO;
      cnt_q     <= '0;
      pulso_q   <= 1'b0;
      estavel_q <= 1'b0;
    end else begin
      sinc1_q   <= botao_n;
      sinc2_q   <= sinc1_q;
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      pulso_q   <= pulso_d;
      estavel_q <= estavel_d;
    end
  end

  assign pulso   = pulso_q;
  assign estavel = estavel_q;

endmodule

// File: rtl/debounce_botoes.sv
// rtl/debounce_botoes.sv - debounced call buttons with latched pending-call register
module debounce_botoes
  import elevador_pkg::*;
#(
  parameter int N_BOTOES   = 4,
  parameter int N_AMOSTRAS = 3
) (
  input logic              clock,
  input logic              reset,
  debounce_botoes_if.slave bus
);

  logic [N_BOTOES-1:0] pulso_w;
  logic [N_BOTOES-1:0] estavel_w;
  logic [N_BOTOES-1:0] chamadas_q, chamadas_d;
  logic                alguma_q, alguma_d;

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
    debounce_canal #(
      .N_AMOSTRAS(N_AMOSTRAS)
    ) u_canal (
      .clock   (clock),
      .reset   (reset),
      .botao_n (bus.botoes_n[i]),
      .pulso   (pulso_w[i]),
      .estavel (estavel_w[i])
    );
  end

  // set is OR-ed in after the clear so a new press beats a same-cycle service
  always_comb begin
    chamadas_d = (chamadas_q & ~bus.atendido) | pulso_w;
    alguma_d   = |chamadas_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      chamadas_q <= '0;
      alguma_q   <= 1'b0;
    end else begin
      chamadas_q <= chamadas_d;
      alguma_q   <= alguma_d;
    end
  end

  assign bus.pulso          = pulso_w;
  assign bus.estavel        = estavel_w;
  assign bus.chamadas       = chamadas_q;
  assign bus.alguma_chamada = alguma_q;

endmodule

// File: tb/tb_debounce_botoes.sv
// tb/tb_debounce_botoes.sv - directed vector bench for debounce_botoes (N_BOTOES=4, N_AMOSTRAS=3)
module tb_debounce_botoes;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  debounce_botoes_if #(.N_BOTOES(4)) bus ();

  debounce_botoes #(
    .N_BOTOES   (4),
    .N_AMOSTRAS (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [3:0] bn;
    logic [3:0] at;
    logic [3:0] ep;
    logic [3:0] ee;
    logic [3:0] ec;
    logic       ea;
  } vetor_t;

  vetor_t tab [0:18];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nome, input logic [3:0] atual, input logic [3:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nome, atual, esperado);
    end
  endtask

  initial begin
    // reset, press on ch0 (pulse at edge 4), 2-sample glitch on ch1, service of ch0
    tab[0]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tab[1]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tab[2]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tab[3]  = '{1'b1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tab[4]  = '{1'b1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tab[5]  = '{1'b1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tab[6]  = '{1'b1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tab[7]  = '{1'b1, 4'hE, 4'h0, 4'h1, 4'h1, 4'h0, 1'b0};
    tab[8]  = '{1'b1, 4'hE, 4'h0, 4'h0, 4'h1, 4'h1, 1'b0};
    tab[9]  = '{1'b1, 4'hE, 4'h0, 4'h0, 4'h1, 4'h1, 1'b1};
    tab[10] = '{1'b1, 4'hC, 4'h0, 4'h0, 4'h1, 4'h1, 1'b1};
    tab[11] = '{1'b1, 4'hC, 4'h0, 4'h0, 4'h1, 4'h1, 1'b1};
    tab[12] = '{1'b1, 4'hE, 4'h0, 4'h0, 4'h1, 4'h1, 1'b1};
    tab[13] = '{1'b1, 4'hE, 4'h0, 4'h0, 4'h1, 4'h1, 1'b1};
    tab[14] = '{1'b1, 4'hE, 4'h0, 4'h0, 4'h1, 4'h1, 1'b1};
    tab[15] = '{1'b1, 4'hE, 4'h0, 4'h0, 4'h1, 4'h1, 1'b1};
    tab[16] = '{1'b1, 4'hE, 4'h1, 4'h0, 4'h1, 4'h0, 1'b1};
    tab[17] = '{1'b1, 4'hE, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0};
    tab[18] = '{1'b1, 4'hE, 4'h4, 4'h0, 4'h1, 4'h0, 1'b0};

    reset        = 1'b0;
    bus.botoes_n = 4'hF;
    bus.atendido = 4'h0;

    for (int i = 0; i <= 18; i++) begin
      reset        = tab[i].rst;
      bus.botoes_n = tab[i].bn;
      bus.atendido = tab[i].at;
      tick();
      check($sformatf("vec%0d pulso", i), bus.pulso, tab[i].ep);
      check($sformatf("vec%0d estavel", i), bus.estavel, tab[i].ee);
      check($sformatf("vec%0d chamadas", i), bus.chamadas, tab[i].ec);
      check($sformatf("vec%0d alguma", i), {3'b000, bus.alguma_chamada}, {3'b000, tab[i].ea});
    end
    bus.atendido = 4'h0;

    // 2-sample release glitch on held ch0: stays pressed, no pulse
    bus.botoes_n = 4'hF;
    for (int e = 0; e < 8; e++) begin
      if (e == 2) bus.botoes_n = 4'hE;
      tick();
      check($sformatf("glitch e%0d pulso0", e), {3'b000, bus.pulso[0]}, 4'h0);
      check($sformatf("glitch e%0d estavel0", e), {3'b000, bus.estavel[0]}, 4'h1);
    end

    // full release of ch0: estavel drops at edge 4, never a pulse
    bus.botoes_n = 4'hF;
    for (int e = 0; e < 8; e++) begin
      tick();
      check($sformatf("solta e%0d pulso0", e), {3'b000, bus.pulso[0]}, 4'h0);
      check($sformatf("solta e%0d estavel0", e), {3'b000, bus.estavel[0]}, (e < 4) ? 4'h1 : 4'h0);
    end

    // ch2: press to latch a call, release, press again and service on the pulse cycle
    bus.botoes_n = 4'hB;
    for (int e = 0; e < 6; e++) begin
      tick();
      check($sformatf("ch2 e%0d pulso", e), bus.pulso, (e == 4) ? 4'h4 : 4'h0);
    end
    check("ch2 chamadas", bus.chamadas, 4'h4);
    bus.botoes_n = 4'hF;
    for (int e = 0; e < 6; e++) begin
      tick();
      check($sformatf("ch2 solta e%0d pulso", e), bus.pulso, 4'h0);
    end
    bus.botoes_n = 4'hB;
    for (int e = 0; e < 5; e++) begin
      tick();
      check($sformatf("ch2 re e%0d pulso", e), bus.pulso, (e == 4) ? 4'h4 : 4'h0);
    end
    bus.atendido = 4'h4;
    tick();
    check("ch2 set wins chamadas", bus.chamadas, 4'h4);
    tick();
    check("ch2 cleared chamadas", bus.chamadas, 4'h0);
    check("ch2 alguma lag", {3'b000, bus.alguma_chamada}, 4'h1);
    bus.atendido = 4'h0;
    tick();
    check("ch2 alguma clear", {3'b000, bus.alguma_chamada}, 4'h0);
    bus.botoes_n = 4'hF;
    for (int e = 0; e < 6; e++) tick();
    check("idle estavel", bus.estavel, 4'h0);

    // reset in the middle of confirming ch0 and ch3, buttons held through release
    bus.botoes_n = 4'h6;
    for (int e = 0; e < 3; e++) tick();
    reset = 1'b0;
    tick();
    check("rst pulso", bus.pulso, 4'h0);
    check("rst estavel", bus.estavel, 4'h0);
    check("rst chamadas", bus.chamadas, 4'h0);
    check("rst alguma", {3'b000, bus.alguma_chamada}, 4'h0);
    reset = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      check($sformatf("pos-rst e%0d pulso", e), bus.pulso, (e == 4) ? 4'h9 : 4'h0);
      if (e == 4) check("pos-rst estavel", bus.estavel, 4'h9);
    end
    check("pos-rst chamadas", bus.chamadas, 4'h9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
